// File: rtl/step_sequencer.sv
// Command-driven step sequencer: issues single-cycle din pulses to the 2-bit
// stepped counter and tracks a mirror of its value, steps issued and abort status.
module step_sequencer #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic [GAP_W-1:0] i_cmd_gap,
    input  logic             i_abort,
    output logic             o_step,
    output logic [CNT_W-1:0] o_count_mirror,
    output logic             o_wrap,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [LEN_W-1:0] o_steps_done
);

    localparam logic [CNT_W-1:0] MIRROR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_mirror;
    logic [LEN_W-1:0]   r_steps_done;
    logic               r_cmd_ready;
    logic               r_step;
    logic               r_wrap;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;

    logic [CNT_W-1:0]   w_mirror_inc;

    assign w_mirror_inc = r_mirror + CNT_W'(1);

    // State and all outputs advance together; outputs are set for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_mirror     <= '0;
            r_steps_done <= '0;
            r_cmd_ready  <= 1'b1;
            r_step       <= 1'b0;
            r_wrap       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_remaining  <= i_cmd_len;
                        r_gap        <= i_cmd_gap;
                        r_steps_done <= '0;
                        r_aborted    <= 1'b0;
                        r_cmd_ready  <= 1'b0;
                        if (i_cmd_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_STEP;
                            r_step  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_wrap  <= (r_mirror == MIRROR_MAX);
                        end
                    end
                end

                ST_STEP: begin
                    // The pulse on the output this cycle is always counted, even under abort.
                    r_mirror     <= w_mirror_inc;
                    r_steps_done <= r_steps_done + LEN_W'(1);
                    r_remaining  <= r_remaining - LEN_W'(1);
                    if (i_abort || (r_remaining == LEN_W'(1))) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_aborted <= i_abort;
                    end else if (r_gap == '0) begin
                        r_step <= 1'b1;
                        r_wrap <= (w_mirror_inc == MIRROR_MAX);
                    end else begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= r_gap;
                    end
                end

                ST_GAP: begin
                    if (i_abort) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_gap_cnt == GAP_W'(1)) begin
                        r_state <= ST_STEP;
                        r_step  <= 1'b1;
                        r_wrap  <= (r_mirror == MIRROR_MAX);
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready    = r_cmd_ready;
    assign o_step         = r_step;
    assign o_count_mirror = r_mirror;
    assign o_wrap         = r_wrap;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_aborted      = r_aborted;
    assign o_steps_done   = r_steps_done;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: cycle-by-cycle expected outputs for
// plain, gapped, zero-length, aborted and reset-interrupted commands.
module tb_step_sequencer;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned GAP_W = 4;

    logic             clk;
    logic             reset;
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [LEN_W-1:0] i_cmd_len;
    logic [GAP_W-1:0] i_cmd_gap;
    logic             i_abort;
    logic             o_step;
    logic [CNT_W-1:0] o_count_mirror;
    logic             o_wrap;
    logic             o_busy;
    logic             o_done;
    logic             o_aborted;
    logic [LEN_W-1:0] o_steps_done;

    int errors = 0;
    int checks = 0;

    step_sequencer #(.CNT_W(CNT_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_len      (i_cmd_len),
        .i_cmd_gap      (i_cmd_gap),
        .i_abort        (i_abort),
        .o_step         (o_step),
        .o_count_mirror (o_count_mirror),
        .o_wrap         (o_wrap),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_aborted      (o_aborted),
        .o_steps_done   (o_steps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock, then check the per-cycle outputs.
    task automatic cyc(input string tag, input int s, input int w, input int d,
                       input int b, input int m, input int sd);
        @(posedge clk);
        #1;
        chk({tag, ".step"},  32'(o_step), s);
        chk({tag, ".wrap"},  32'(o_wrap), w);
        chk({tag, ".done"},  32'(o_done), d);
        chk({tag, ".busy"},  32'(o_busy), b);
        chk({tag, ".mirror"}, 32'(o_count_mirror), m);
        chk({tag, ".sdone"}, 32'(o_steps_done), sd);
    endtask

    task automatic send(input int len, input int gap);
        i_cmd_valid = 1'b1;
        i_cmd_len   = LEN_W'(len);
        i_cmd_gap   = GAP_W'(gap);
    endtask

    initial begin
        reset       = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd_len   = 8'd7;
        i_cmd_gap   = 4'd0;
        i_abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        reset       = 1'b0;
        chk("rst.ready", 32'(o_cmd_ready), 1);
        chk("rst.step", 32'(o_step), 0);
        chk("rst.busy", 32'(o_busy), 0);
        chk("rst.done", 32'(o_done), 0);
        chk("rst.aborted", 32'(o_aborted), 0);
        chk("rst.mirror", 32'(o_count_mirror), 0);
        chk("rst.sdone", 32'(o_steps_done), 0);

        // len=3 gap=0: three back-to-back steps, mirror 0->3, no wrap
        send(3, 0);
        cyc("t1.s1", 1, 0, 0, 1, 0, 0);
        i_cmd_valid = 1'b0;
        chk("t1.s1.ready", 32'(o_cmd_ready), 0);
        cyc("t1.s2", 1, 0, 0, 1, 1, 1);
        cyc("t1.s3", 1, 0, 0, 1, 2, 2);
        cyc("t1.done", 0, 0, 1, 0, 3, 3);
        chk("t1.done.ready", 32'(o_cmd_ready), 0);
        cyc("t1.idle", 0, 0, 0, 0, 3, 3);
        chk("t1.idle.ready", 32'(o_cmd_ready), 1);

        // len=6 gap=2 from mirror 3: wrap on steps 1 and 5, final mirror 1
        send(6, 2);
        for (int k = 0; k < 6; k++) begin
            cyc($sformatf("t2.step%0d", k), 1, int'(k == 0 || k == 4), 0, 1, (3 + k) % 4, k);
            if (k == 0) i_cmd_valid = 1'b0;
            if (k < 5) begin
                cyc($sformatf("t2.gapa%0d", k), 0, 0, 0, 1, (4 + k) % 4, k + 1);
                cyc($sformatf("t2.gapb%0d", k), 0, 0, 0, 1, (4 + k) % 4, k + 1);
            end
        end
        cyc("t2.done", 0, 0, 1, 0, 1, 6);
        cyc("t2.idle", 0, 0, 0, 0, 1, 6);

        // len=0: straight to DONE, mirror untouched
        send(0, 5);
        cyc("t3.done", 0, 0, 1, 0, 1, 0);
        i_cmd_valid = 1'b0;
        chk("t3.done.ready", 32'(o_cmd_ready), 0);
        cyc("t3.idle", 0, 0, 0, 0, 1, 0);
        chk("t3.idle.ready", 32'(o_cmd_ready), 1);

        // len=10 gap=3, abort in 2nd gap cycle after step 2
        send(10, 3);
        cyc("t4.s1", 1, 0, 0, 1, 1, 0);
        i_cmd_valid = 1'b0;
        cyc("t4.g1a", 0, 0, 0, 1, 2, 1);
        cyc("t4.g1b", 0, 0, 0, 1, 2, 1);
        cyc("t4.g1c", 0, 0, 0, 1, 2, 1);
        cyc("t4.s2", 1, 0, 0, 1, 2, 1);
        cyc("t4.g2a", 0, 0, 0, 1, 3, 2);
        cyc("t4.g2b", 0, 0, 0, 1, 3, 2);
        i_abort = 1'b1;
        cyc("t4.done", 0, 0, 1, 0, 3, 2);
        i_abort = 1'b0;
        chk("t4.aborted", 32'(o_aborted), 1);
        cyc("t4.idle", 0, 0, 0, 0, 3, 2);
        chk("t4.idle.aborted", 32'(o_aborted), 1);

        // len=5 gap=0, abort on the 4th step: that step counts
        send(5, 0);
        cyc("t5.s1", 1, 1, 0, 1, 3, 0);
        i_cmd_valid = 1'b0;
        chk("t5.accept.aborted", 32'(o_aborted), 0);
        cyc("t5.s2", 1, 0, 0, 1, 0, 1);
        cyc("t5.s3", 1, 0, 0, 1, 1, 2);
        cyc("t5.s4", 1, 0, 0, 1, 2, 3);
        i_abort = 1'b1;
        cyc("t5.done", 0, 0, 1, 0, 3, 4);
        i_abort = 1'b0;
        chk("t5.aborted", 32'(o_aborted), 1);
        cyc("t5.idle", 0, 0, 0, 0, 3, 4);

        // reset in GAP after 3 steps, cmd_valid held through reset
        send(8, 1);
        cyc("t6.s1", 1, 1, 0, 1, 3, 0);
        cyc("t6.g1", 0, 0, 0, 1, 0, 1);
        cyc("t6.s2", 1, 0, 0, 1, 0, 1);
        cyc("t6.g2", 0, 0, 0, 1, 1, 2);
        cyc("t6.s3", 1, 0, 0, 1, 1, 2);
        cyc("t6.g3", 0, 0, 0, 1, 2, 3);
        i_cmd_len = 8'd4;
        i_cmd_gap = 4'd0;
        reset     = 1'b1;
        cyc("t6.rst", 0, 0, 0, 0, 0, 0);
        chk("t6.rst.ready", 32'(o_cmd_ready), 1);
        chk("t6.rst.aborted", 32'(o_aborted), 0);
        reset       = 1'b0;
        i_cmd_valid = 1'b0;
        cyc("t6.after", 0, 0, 0, 0, 0, 0);
        chk("t6.after.ready", 32'(o_cmd_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
